// File: rtl/gshare_bht.sv
// -----------------------------------------------------------------------------
// gshare_bht
//   Global-history (gshare) branch direction predictor. The table holds
//   SATUR_COUNT_W-bit saturating counters, indexed by the PC index bits XORed
//   with the global history register (GHR).
//   Fetch reads a prediction combinationally and speculatively shifts the GHR.
//   Execute trains the table and repairs the GHR on a mispredict.
//
// Ports
//   clk_i             clock
//   arst_i            asynchronous active-high reset
//   stall_fetch_i     freezes every counter and GHR write
//   pred_valid_i      fetch holds a branch this cycle (shifts the GHR)
//   set_index_i       fetch PC index bits
//   bht_pred_taken_o  predicted direction (counter MSB)
//   pred_ghr_o        GHR snapshot used for this prediction
//   bht_update_i      resolved branch present in execute
//   branch_taken_i    resolved direction
//   set_index_exec_i  execute PC index bits
//   update_ghr_i      GHR snapshot carried down the pipe with the branch
//   mispredict_i      direction mispredicted (qualified by bht_update_i)
//
// Handshake: there is no ready/back-pressure signal. pred_valid_i and
// bht_update_i are single-cycle qualifiers; a transfer happens on a clock edge
// where the qualifier is high and stall_fetch_i is low. While stalled, the
// producer keeps the execute inputs stable until the stall drops.
// -----------------------------------------------------------------------------
module gshare_bht #(
   parameter int SET_COUNT     = 32,
   parameter int INDEX_WIDTH   = 5,
   parameter int SATUR_COUNT_W = 2,
   parameter int HIST_W        = 4,
   parameter int RESET_STATE   = 1
) (
   input  logic                   clk_i,
   input  logic                   arst_i,
   input  logic                   stall_fetch_i,
   input  logic                   pred_valid_i,
   input  logic [INDEX_WIDTH-1:0] set_index_i,
   output logic                   bht_pred_taken_o,
   output logic [HIST_W-1:0]      pred_ghr_o,
   input  logic                   bht_update_i,
   input  logic                   branch_taken_i,
   input  logic [INDEX_WIDTH-1:0] set_index_exec_i,
   input  logic [HIST_W-1:0]      update_ghr_i,
   input  logic                   mispredict_i
);

   localparam logic [SATUR_COUNT_W-1:0] CTR_RST = SATUR_COUNT_W'(RESET_STATE);
   localparam logic [SATUR_COUNT_W-1:0] CTR_MAX = '1;

   logic [SATUR_COUNT_W-1:0] ctr_q [SET_COUNT];
   logic [HIST_W-1:0]        ghr_q;
   logic [HIST_W-1:0]        ghr_next;
   logic [INDEX_WIDTH-1:0]   pidx;
   logic [INDEX_WIDTH-1:0]   uidx;
   logic [SATUR_COUNT_W-1:0] ctr_cur;
   logic [SATUR_COUNT_W-1:0] ctr_next;
   logic                     do_train;

   // History is shorter than (or equal to) the index; the cast zero-extends it.
   assign pidx = set_index_i ^ INDEX_WIDTH'(ghr_q);
   assign uidx = set_index_exec_i ^ INDEX_WIDTH'(update_ghr_i);

   // Reads come straight from the registered table, so a same-cycle write to
   // the same entry is only seen on the following cycle.
   assign bht_pred_taken_o = ctr_q[pidx][SATUR_COUNT_W-1];
   assign pred_ghr_o       = ghr_q;

   assign do_train = bht_update_i & ~stall_fetch_i;

   // Saturating increment/decrement; the counter never wraps.
   always_comb begin
      ctr_cur  = ctr_q[uidx];
      ctr_next = ctr_cur;
      if (branch_taken_i) begin
         if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
      end else begin
         if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
      end
   end

   // Repair beats the speculative shift: a mispredict means the fetch-side
   // history is on the wrong path, so any same-cycle shift is thrown away.
   always_comb begin
      ghr_next = ghr_q;
      if (!stall_fetch_i) begin
         if (bht_update_i && mispredict_i) begin
            ghr_next = {update_ghr_i[HIST_W-2:0], branch_taken_i};
         end else if (pred_valid_i) begin
            ghr_next = {ghr_q[HIST_W-2:0], bht_pred_taken_o};
         end
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         ghr_q <= '0;
         for (int i = 0; i < SET_COUNT; i++) begin
            ctr_q[i] <= CTR_RST;
         end
      end else begin
         ghr_q <= ghr_next;
         if (do_train) begin
            ctr_q[uidx] <= ctr_next;
         end
      end
   end

endmodule

// File: tb/tb_gshare_bht.sv
// -----------------------------------------------------------------------------
// tb_gshare_bht
//   Directed bench for gshare_bht with default parameters. Inputs change 1 time
//   unit after the rising edge; outputs are sampled 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_gshare_bht;

   localparam int IW = 5;
   localparam int HW = 4;

   logic          clk_i;
   logic          arst_i;
   logic          stall_fetch_i;
   logic          pred_valid_i;
   logic [IW-1:0] set_index_i;
   logic          bht_pred_taken_o;
   logic [HW-1:0] pred_ghr_o;
   logic          bht_update_i;
   logic          branch_taken_i;
   logic [IW-1:0] set_index_exec_i;
   logic [HW-1:0] update_ghr_i;
   logic          mispredict_i;

   int total = 0;
   int bad   = 0;

   // Expected GHR snapshots for the speculative-shift sequence.
   logic [HW-1:0] exp_q[$];

   gshare_bht dut (
      .clk_i            (clk_i),
      .arst_i           (arst_i),
      .stall_fetch_i    (stall_fetch_i),
      .pred_valid_i     (pred_valid_i),
      .set_index_i      (set_index_i),
      .bht_pred_taken_o (bht_pred_taken_o),
      .pred_ghr_o       (pred_ghr_o),
      .bht_update_i     (bht_update_i),
      .branch_taken_i   (branch_taken_i),
      .set_index_exec_i (set_index_exec_i),
      .update_ghr_i     (update_ghr_i),
      .mispredict_i     (mispredict_i)
   );

   // ---------------------------------------------------------------- clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------------------------------------------------------- checker
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- drivers
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      stall_fetch_i    = 1'b0;
      pred_valid_i     = 1'b0;
      set_index_i      = '0;
      bht_update_i     = 1'b0;
      branch_taken_i   = 1'b0;
      set_index_exec_i = '0;
      update_ghr_i     = '0;
      mispredict_i     = 1'b0;
   endtask

   // One execute-stage update, applied on the next edge.
   task automatic do_update(input logic [IW-1:0] idx, input logic [HW-1:0] ghr,
                            input logic taken, input logic mis);
      set_index_exec_i = idx;
      update_ghr_i     = ghr;
      branch_taken_i   = taken;
      mispredict_i     = mis;
      bht_update_i     = 1'b1;
      step();
      bht_update_i     = 1'b0;
      mispredict_i     = 1'b0;
   endtask

   // Look up a prediction without shifting history.
   task automatic peek(input string tag, input logic [IW-1:0] idx, input logic exp_pred);
      set_index_i = idx;
      #1;
      check(tag, 32'(bht_pred_taken_o), 32'(exp_pred));
   endtask

   // Fetch a branch: check prediction and snapshot, then shift on the edge.
   task automatic fetch(input string tag, input logic [IW-1:0] idx, input logic exp_pred);
      logic [HW-1:0] exp_ghr;
      set_index_i  = idx;
      pred_valid_i = 1'b1;
      #1;
      exp_ghr = exp_q.pop_front();
      check({tag, "_pred"}, 32'(bht_pred_taken_o), 32'(exp_pred));
      check({tag, "_ghr"},  32'(pred_ghr_o),       32'(exp_ghr));
      step();
      pred_valid_i = 1'b0;
   endtask

   // ---------------------------------------------------------------- stimulus
   logic exp_up [4];
   logic exp_dn [4];

   initial begin
      idle_inputs();
      arst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      arst_i = 1'b0;
      #1;

      // 1. Reset: every entry weakly not taken, GHR cleared.
      check("rst_ghr", 32'(pred_ghr_o), 32'h0);
      for (int i = 0; i < 32; i++) begin
         peek($sformatf("rst_pred%0d", i), IW'(i), 1'b0);
      end
      peek("rst_pred_last", 5'd31, 1'b0);

      // 2. Saturation on entry 3 (GHR = 0, update_ghr = 0).
      //    up:   01->10->11->11->11   preds 1,1,1,1
      //    down: 11->10->01->00->00   preds 1,0,0,0
      exp_up = '{1'b1, 1'b1, 1'b1, 1'b1};
      exp_dn = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         do_update(5'd3, 4'h0, 1'b1, 1'b0);
         peek($sformatf("sat_up%0d", i), 5'd3, exp_up[i]);
      end
      for (int i = 0; i < 4; i++) begin
         do_update(5'd3, 4'h0, 1'b0, 1'b0);
         peek($sformatf("sat_dn%0d", i), 5'd3, exp_dn[i]);
      end
      // From 00 a taken gives 01 (pred 0), then 10 (pred 1): no wrap occurred.
      do_update(5'd3, 4'h0, 1'b1, 1'b0);
      peek("sat_nowrap0", 5'd3, 1'b0);
      do_update(5'd3, 4'h0, 1'b1, 1'b0);
      peek("sat_nowrap1", 5'd3, 1'b1);

      // 3. Speculative shift. Preload ctr[8] and ctr[10] to 10; ctr[9] stays 01.
      //    Fetch idx 8 three times: pidx 8 (GHR 0000), 9 (0001), 10 (0010).
      do_update(5'd8,  4'h0, 1'b1, 1'b0);
      do_update(5'd10, 4'h0, 1'b1, 1'b0);
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      fetch("spec0", 5'd8, 1'b1);
      fetch("spec1", 5'd8, 1'b0);
      fetch("spec2", 5'd8, 1'b1);
      check("spec_ghr", 32'(pred_ghr_o), 32'b0101);

      // 4. Repair. Force GHR to 1111 via a repair ({111,1}), then a repair with
      //    a simultaneous fetch: repair wins -> {010,1} = 0101.
      do_update(5'd20, 4'b0111, 1'b1, 1'b1);
      check("repair_set1111", 32'(pred_ghr_o), 32'b1111);
      pred_valid_i = 1'b1;
      set_index_i  = 5'd0;
      do_update(5'd20, 4'b0010, 1'b1, 1'b1);
      pred_valid_i = 1'b0;
      check("repair_wins", 32'(pred_ghr_o), 32'b0101);

      // 5. Hashing and read-during-write. GHR <- {011,0} = 0110.
      do_update(5'd20, 4'b0011, 1'b0, 1'b1);
      check("hash_ghr", 32'(pred_ghr_o), 32'b0110);
      peek("hash_idx6_reads_ctr0", 5'b00110, 1'b0);
      peek("hash_idx0_reads_ctr6", 5'b00000, 1'b0);
      set_index_i      = 5'b00110;
      set_index_exec_i = 5'd0;
      update_ghr_i     = 4'h0;
      branch_taken_i   = 1'b1;
      mispredict_i     = 1'b0;
      bht_update_i     = 1'b1;
      #1;
      check("rdw_old", 32'(bht_pred_taken_o), 32'h0);
      step();
      bht_update_i = 1'b0;
      #1;
      check("rdw_new", 32'(bht_pred_taken_o), 32'h1);
      check("rdw_ghr_hold", 32'(pred_ghr_o), 32'b0110);

      // 6a. Stall blocks training and the repair/shift.
      stall_fetch_i    = 1'b1;
      pred_valid_i     = 1'b1;
      set_index_i      = 5'b00110;
      bht_update_i     = 1'b1;
      set_index_exec_i = 5'd0;
      update_ghr_i     = 4'h0;
      branch_taken_i   = 1'b0;
      mispredict_i     = 1'b1;
      step();
      step();
      idle_inputs();
      #1;
      check("stall_ghr", 32'(pred_ghr_o), 32'b0110);
      peek("stall_ctr0", 5'b00110, 1'b1);

      // 6b. Asynchronous reset mid-stream with an update and fetch in flight.
      pred_valid_i     = 1'b1;
      set_index_i      = 5'd8;
      bht_update_i     = 1'b1;
      set_index_exec_i = 5'd8;
      update_ghr_i     = 4'h0;
      branch_taken_i   = 1'b1;
      mispredict_i     = 1'b1;
      #1;
      arst_i = 1'b1;
      #1;
      check("arst_ghr_now", 32'(pred_ghr_o), 32'h0);
      check("arst_ctr8_now", 32'(bht_pred_taken_o), 32'h0);
      step();
      arst_i = 1'b0;
      idle_inputs();
      #1;
      check("arst_ghr_after", 32'(pred_ghr_o), 32'h0);
      peek("arst_ctr0",  5'd0,  1'b0);
      peek("arst_ctr3",  5'd3,  1'b0);
      peek("arst_ctr8",  5'd8,  1'b0);
      peek("arst_ctr10", 5'd10, 1'b0);
      peek("arst_ctr19", 5'd19, 1'b0);
      // Counter must be 01 (not 00): one taken flips the prediction.
      do_update(5'd3, 4'h0, 1'b1, 1'b0);
      peek("arst_ctr3_is01", 5'd3, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
